// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - K&S core shared types: decoded instruction enumeration
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNZERO,
    I_BNNEG,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

endpackage

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - K&S PC/IR holder, RAM address mux and instruction decoder
// Optional sticky illegal-opcode trap enabled by defining ILLEGAL_OP_TRAP_EN.
module fetch_decode_unit
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    branch,
  input  logic                    addr_sel,
  input  logic [DATA_W-1:0]       data_in,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [ADDR_W-1:0]       pc,
  output decoded_instruction_type decoded_instruction,
  output logic [1:0]              a_addr,
  output logic [1:0]              b_addr,
  output logic [1:0]              c_addr,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic                    illegal_op,
`endif
  output logic [ADDR_W-1:0]       mem_addr
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              is_illegal;
  logic              unused_ir_bit7;

  assign unused_ir_bit7 = ir_q[7];
  assign mem_addr       = ir_q[ADDR_W-1:0];
  assign pc             = pc_q;
  assign ram_addr       = addr_sel ? mem_addr : pc_q;

  // Branch target comes from the IR as it stood before this edge.
  always_comb begin
    pc_d = pc_q;
    if (pc_enable) begin
      pc_d = branch ? mem_addr : pc_q + ADDR_W'(1);
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (ir_enable) begin
      ir_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  always_comb begin
    decoded_instruction = I_NOP;
    a_addr              = 2'd0;
    b_addr              = 2'd0;
    c_addr              = 2'd0;
    is_illegal          = 1'b0;
    case (ir_q[15:8])
      8'h00: decoded_instruction = I_NOP;
      8'h81: begin
        decoded_instruction = I_LOAD;
        c_addr              = ir_q[6:5];
      end
      8'h82: begin
        decoded_instruction = I_STORE;
        a_addr              = ir_q[6:5];
      end
      8'h91: begin
        decoded_instruction = I_MOVE;
        c_addr              = ir_q[3:2];
        a_addr              = ir_q[1:0];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        case (ir_q[10:8])
          3'd1:    decoded_instruction = I_ADD;
          3'd2:    decoded_instruction = I_SUB;
          3'd3:    decoded_instruction = I_AND;
          default: decoded_instruction = I_OR;
        endcase
        c_addr = ir_q[5:4];
        a_addr = ir_q[3:2];
        b_addr = ir_q[1:0];
      end
      8'h01: decoded_instruction = I_BRANCH;
      8'h02: decoded_instruction = I_BZERO;
      8'h03: decoded_instruction = I_BNEG;
      8'h04: decoded_instruction = I_BOV;
      8'h0A: decoded_instruction = I_BNZERO;
      8'h0B: decoded_instruction = I_BNNEG;
      8'h0C: decoded_instruction = I_BNOV;
      8'hFF: decoded_instruction = I_HALT;
      default: begin
        is_illegal = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
        decoded_instruction = I_HALT;
`else
        decoded_instruction = I_NOP;
`endif
      end
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky until reset: once an unknown opcode has sat in the IR, the trap holds.
  assign illegal_d  = illegal_q | is_illegal;
  assign illegal_op = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`else
  logic unused_is_illegal;
  assign unused_is_illegal = is_illegal;
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - directed self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;
  import k_and_s_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    pc_enable, ir_enable, branch, addr_sel;
  logic [15:0]             data_in;
  logic [4:0]              ram_addr, pc, mem_addr;
  decoded_instruction_type decoded_instruction;
  logic [1:0]              a_addr, b_addr, c_addr;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                    illegal_op;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_decode_unit #(.ADDR_W(5), .DATA_W(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .branch              (branch),
    .addr_sel            (addr_sel),
    .data_in             (data_in),
    .ram_addr            (ram_addr),
    .pc                  (pc),
    .decoded_instruction (decoded_instruction),
    .a_addr              (a_addr),
    .b_addr              (b_addr),
    .c_addr              (c_addr),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op          (illegal_op),
`endif
    .mem_addr            (mem_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic pe, input logic ie, input logic br, input logic [15:0] d);
    pc_enable = pe;
    ir_enable = ie;
    branch    = br;
    data_in   = d;
    @(posedge clk);
    #1;
    pc_enable = 1'b0;
    ir_enable = 1'b0;
    branch    = 1'b0;
  endtask

  typedef struct {
    logic [7:0] op;
    decoded_instruction_type exp;
  } op_vec_t;

  op_vec_t ops[16] = '{
    '{8'h00, I_NOP},    '{8'h81, I_LOAD},   '{8'h82, I_STORE},  '{8'h91, I_MOVE},
    '{8'hA1, I_ADD},    '{8'hA2, I_SUB},    '{8'hA3, I_AND},    '{8'hA4, I_OR},
    '{8'h01, I_BRANCH}, '{8'h02, I_BZERO},  '{8'h03, I_BNEG},   '{8'h04, I_BOV},
    '{8'h0A, I_BNZERO}, '{8'h0B, I_BNNEG},  '{8'h0C, I_BNOV},   '{8'hFF, I_HALT}
  };

  initial begin
    rst_n = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; branch = 1'b0;
    addr_sel = 1'b0; data_in = 16'h0000;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_dec", int'(decoded_instruction), int'(I_NOP));
    chk("rst_fields", {a_addr, b_addr, c_addr, mem_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) step(1, 1, 0, 16'h0000);
    chk("fetch_pc3", pc, 3);
    step(1, 1, 0, 16'hA11B);
    chk("add_pc", pc, 4);
    chk("add_dec", int'(decoded_instruction), int'(I_ADD));
    chk("add_c", c_addr, 1);
    chk("add_a", a_addr, 2);
    chk("add_b", b_addr, 3);
    chk("add_mem", mem_addr, 5'h1B);
    chk("add_ram_pc", ram_addr, 4);

    step(0, 1, 0, 16'h0112);
    chk("br_ir_pc_hold", pc, 4);
    chk("br_dec", int'(decoded_instruction), int'(I_BRANCH));
    step(0, 0, 1, 16'hFFFF);
    chk("br_no_pcen", pc, 4);
    chk("ir_hold", int'(decoded_instruction), int'(I_BRANCH));
    step(1, 1, 1, 16'h0107);
    chk("br_old_ir_target", pc, 18);
    chk("br_new_ir_mem", mem_addr, 7);
    step(1, 0, 1, 16'h0000);
    chk("br_to7", pc, 7);

    step(0, 1, 0, 16'h011F);
    step(1, 0, 1, 16'h0000);
    chk("pc31", pc, 31);
    step(1, 0, 0, 16'h0000);
    chk("pc_wrap", pc, 0);

    step(0, 1, 0, 16'h8165);
    chk("ld_dec", int'(decoded_instruction), int'(I_LOAD));
    chk("ld_fields", {a_addr, b_addr, c_addr}, 6'b00_00_11);
    addr_sel = 1'b1; #1;
    chk("ld_ram_mem", ram_addr, 5);
    addr_sel = 1'b0; #1;
    chk("ld_ram_pc", ram_addr, 0);

    step(0, 1, 0, 16'h8240);
    chk("st_fields", {a_addr, b_addr, c_addr}, 6'b10_00_00);
    step(0, 1, 0, 16'h910E);
    chk("mv_fields", {a_addr, b_addr, c_addr}, 6'b10_00_11);

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, {ops[i].op, 8'h00});
      chk($sformatf("dec_%02h", ops[i].op), int'(decoded_instruction), int'(ops[i].exp));
    end

    step(0, 1, 0, 16'h7700);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_dec", int'(decoded_instruction), int'(I_HALT));
    chk("ill_not_yet", illegal_op, 0);
    step(0, 1, 0, 16'h0000);
    chk("ill_set", illegal_op, 1);
    step(0, 0, 0, 16'h0000);
    chk("ill_sticky", illegal_op, 1);
`else
    chk("ill_dec", int'(decoded_instruction), int'(I_NOP));
`endif

    step(0, 1, 0, 16'h0107);
    step(1, 0, 1, 16'h0000);
    chk("pre_rst_pc7", pc, 7);
    #2;
    rst_n = 1'b0;
    addr_sel = 1'b1;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ram", ram_addr, 0);
    chk("async_rst_dec", int'(decoded_instruction), int'(I_NOP));
`ifdef ILLEGAL_OP_TRAP_EN
    chk("async_rst_ill", illegal_op, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Instruction-side datapath stage of the K&S core. Holds the program counter (PC) and instruction register (IR).
- Drives the RAM address mux and decodes the IR into a `decoded_instruction_type` value plus register and memory operand fields.
- Sits directly upstream of `control_unit`: it consumes `pc_enable`, `ir_enable`, `branch` and `addr_sel`, and produces the `decoded_instruction` that `control_unit` sequences on.

Parameters:
- ADDR_W, 5, RAM word-address width; PC and memory-operand field width.
- DATA_W, 16, instruction/RAM word width; fixed encoding requires 16.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_enable  input  1  update PC this cycle.
- ir_enable  input  1  load IR from data_in this cycle.
- branch  input  1  with pc_enable: PC loads mem_addr instead of PC+1.
- addr_sel  input  1  0: ram_addr=PC; 1: ram_addr=mem_addr.
- data_in  input  DATA_W  RAM read data.
- ram_addr  output  ADDR_W  RAM word address.
- pc  output  ADDR_W  current PC.
- decoded_instruction  output  decoded_instruction_type  decode of IR (enum from k_and_s_pkg).
- a_addr, b_addr, c_addr  output  2 each  register-file operand fields.
- mem_addr  output  ADDR_W  memory/branch-target field, IR[ADDR_W-1:0].
- illegal_op  output  1  sticky illegal-opcode flag; present only with ILLEGAL_OP_TRAP_EN.

Behaviour:
- Reset (async, any cycle, mid-operation included): PC=0, IR=16'h0000, illegal_op=0. Outputs settle combinationally: decoded=I_NOP, ram_addr=0, fields=0.
- PC update, only on a rising edge with pc_enable=1:
  - branch=1: PC <= mem_addr of the current IR.
  - branch=0: PC <= PC+1, modulo 2^ADDR_W (31 wraps to 0).
  - branch=1 with pc_enable=0: no effect.
- IR update: on a rising edge with ir_enable=1, IR <= data_in; otherwise IR holds.
- Simultaneous ir_enable and pc_enable (fetch cycle):
  - IR takes the word at the old PC; PC increments in the same edge.
  - Branch target, if used, comes from the old IR, never from data_in.
- ram_addr is combinational from addr_sel, PC and IR; zero latency.
- decoded_instruction and all fields are combinational from IR only. They change the cycle after ir_enable, never directly from data_in.
- Decode on IR[15:8]:
  - 00 I_NOP
  - 81 I_LOAD, 82 I_STORE, 91 I_MOVE
  - A1 I_ADD, A2 I_SUB, A3 I_AND, A4 I_OR
  - 01 I_BRANCH, 02 I_BZERO, 03 I_BNEG, 04 I_BOV
  - 0A I_BNZERO, 0B I_BNNEG, 0C I_BNOV
  - FF I_HALT
- Field mapping:
  - ALU ops: c_addr=IR[5:4], a_addr=IR[3:2], b_addr=IR[1:0].
  - LOAD: c_addr=IR[6:5].
  - STORE: a_addr=IR[6:5].
  - MOVE: c_addr=IR[3:2], a_addr=IR[1:0].
  - Unused fields are 0.
- mem_addr is always IR[ADDR_W-1:0], for every opcode.
- Unlisted opcodes are handled per the optional feature below.
- No internal state machine. PC and IR are the only state, plus illegal_op when the feature is enabled.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Unlisted opcodes decode to I_HALT.
  - illegal_op is set on the edge after an illegal IR load and stays 1 until reset.
  - The illegal_op port exists.
- Undefined:
  - Unlisted opcodes decode to I_NOP.
  - No illegal_op port, no sticky register.

Test Plan:
- Reset then release: PC=0, ram_addr=0, decoded=I_NOP. Assert rst_n low mid-run with PC=7 -> PC=0 immediately, with no clock edge.
- data_in=16'hA1_1B with ir_enable=pc_enable=1 at PC=3 -> next cycle IR=A11B, decoded=I_ADD, c_addr=1, a_addr=2, b_addr=3, PC=4.
- IR=16'h0112, pc_enable=branch=1 -> PC=18. branch=1 with pc_enable=0 -> PC unchanged.
- PC=31, pc_enable=1, branch=0 -> PC=0.
- IR=16'h8105 (LOAD): addr_sel=1 -> ram_addr=5; addr_sel=0 -> ram_addr=PC.
- Load IR=16'h7700: with ILLEGAL_OP_TRAP_EN -> decoded=I_HALT and illegal_op=1, held after a later IR=0000 load. Without the macro -> decoded=I_NOP.
